// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee machine order controller.
//   - state_e     : order controller state encoding
//   - Coin*       : coin input codes, coin_value() maps a code to its worth in units
//   - Drink*      : drink selection codes
//   - DefPrice*   : default drink prices in units
package coffee_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StCredit   = 3'd1,
    StError    = 3'd2,
    StDispense = 3'd3,
    StWaitDone = 3'd4
  } state_e;

  localparam logic [1:0] CoinNone = 2'b00;
  localparam logic [1:0] Coin1    = 2'b01;
  localparam logic [1:0] Coin2    = 2'b10;
  localparam logic [1:0] Coin5    = 2'b11;

  localparam logic [1:0] Drink0 = 2'b00;
  localparam logic [1:0] Drink1 = 2'b01;
  localparam logic [1:0] Drink2 = 2'b10;
  localparam logic [1:0] Drink3 = 2'b11;

  localparam int unsigned DefPrice0 = 3;
  localparam int unsigned DefPrice1 = 4;
  localparam int unsigned DefPrice2 = 5;
  localparam int unsigned DefPrice3 = 6;

  // Wide enough for the largest coin (5 units).
  localparam int unsigned CoinValW = 3;

  function automatic logic [CoinValW-1:0] coin_value(input logic [1:0] code);
    logic [CoinValW-1:0] val;
    case (code)
      Coin1:   val = 3'd1;
      Coin2:   val = 3'd2;
      Coin5:   val = 3'd5;
      default: val = 3'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/coffee_price_lut.sv
// Drink price lookup and credit sufficiency compare.
//   drink_sel_i  : drink code
//   credit_i     : current credit
//   price_o      : price of the selected drink
//   sufficient_o : credit_i >= price_o
module coffee_price_lut
  import coffee_pkg::*;
#(
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned PRICE0   = DefPrice0,
  parameter int unsigned PRICE1   = DefPrice1,
  parameter int unsigned PRICE2   = DefPrice2,
  parameter int unsigned PRICE3   = DefPrice3
) (
  input  logic [1:0]          drink_sel_i,
  input  logic [CREDIT_W-1:0] credit_i,
  output logic [CREDIT_W-1:0] price_o,
  output logic                sufficient_o
);

  always_comb begin
    price_o = CREDIT_W'(PRICE0);
    unique case (drink_sel_i)
      Drink0: price_o = CREDIT_W'(PRICE0);
      Drink1: price_o = CREDIT_W'(PRICE1);
      Drink2: price_o = CREDIT_W'(PRICE2);
      Drink3: price_o = CREDIT_W'(PRICE3);
      default: price_o = CREDIT_W'(PRICE0);
    endcase
  end

  assign sufficient_o = (credit_i >= price_o);

endmodule

// File: rtl/coffee_order_ctrl.sv
// Payment and selection stage of the coffee machine.
// Accumulates coins into a saturating credit register, evaluates orders on confirm and
// issues ENTER (valid order) or ERRO (insufficient credit) to the dispensing FSM.
//   clk, reset   : clock and synchronous active-high reset
//   coin         : coin code (00 none, 01 = 1, 10 = 2, 11 = 5 units)
//   drink_sel    : drink code sampled on confirm
//   confirm      : order request
//   cancel       : abort, refunds the credit
//   drink_done   : dispensing finished pulse
//   ENTER        : one-cycle valid-order strobe
//   ERRO         : insufficient-credit level, ERR_CYCLES long
//   drink_out    : latched drink code while dispensing
//   credit       : current credit
//   change_valid : one-cycle change/refund pulse, change_amt valid with it
//   coin_reject  : one-cycle pulse when a coin is returned
//   busy         : order in progress (dispensing or waiting for done)
module coffee_order_ctrl
  import coffee_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 4,
  parameter int unsigned MAX_CREDIT = 15,
  parameter int unsigned PRICE0     = DefPrice0,
  parameter int unsigned PRICE1     = DefPrice1,
  parameter int unsigned PRICE2     = DefPrice2,
  parameter int unsigned PRICE3     = DefPrice3,
  parameter int unsigned ERR_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic [1:0]          drink_sel,
  input  logic                confirm,
  input  logic                cancel,
  input  logic                drink_done,
  output logic                ENTER,
  output logic                ERRO,
  output logic [1:0]          drink_out,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic                busy
);

  localparam int unsigned SumW = CREDIT_W + 1;
  localparam int unsigned CntW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  enter_q, enter_d;
  logic                  erro_q, erro_d;
  logic [1:0]            drink_q, drink_d;
  logic                  chg_valid_q, chg_valid_d;
  logic [CREDIT_W-1:0]   chg_amt_q, chg_amt_d;
  logic                  coin_rej_q, coin_rej_d;
  logic [CntW-1:0]       err_cnt_q, err_cnt_d;

  logic [CREDIT_W-1:0]   price;
  logic                  sufficient;
  logic                  coin_nz;
  logic [SumW-1:0]       coin_sum;
  logic                  coin_ovf;

  coffee_price_lut #(
    .CREDIT_W (CREDIT_W),
    .PRICE0   (PRICE0),
    .PRICE1   (PRICE1),
    .PRICE2   (PRICE2),
    .PRICE3   (PRICE3)
  ) u_price_lut (
    .drink_sel_i  (drink_sel),
    .credit_i     (credit_q),
    .price_o      (price),
    .sufficient_o (sufficient)
  );

  assign coin_nz  = (coin != CoinNone);
  // One extra bit so the saturation check sees the true sum.
  assign coin_sum = {1'b0, credit_q} + SumW'(coin_value(coin));
  assign coin_ovf = (coin_sum > SumW'(MAX_CREDIT));

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    enter_d     = 1'b0;
    erro_d      = 1'b0;
    drink_d     = drink_q;
    chg_valid_d = 1'b0;
    chg_amt_d   = chg_amt_q;
    coin_rej_d  = 1'b0;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      StIdle, StCredit, StError: begin
        // ERRO hold timer; later branches may override the outcome.
        if (state_q == StError) begin
          if (err_cnt_q == '0) begin
            state_d = StCredit;
          end else begin
            erro_d    = 1'b1;
            err_cnt_d = err_cnt_q - 1'b1;
          end
        end

        if (cancel) begin
          chg_valid_d = 1'b1;
          chg_amt_d   = credit_q;
          credit_d    = '0;
          erro_d      = 1'b0;
          err_cnt_d   = '0;
          state_d     = StIdle;
          coin_rej_d  = coin_nz;
        end else if (confirm) begin
          // Evaluated against the pre-coin credit; a concurrent coin is returned.
          coin_rej_d = coin_nz;
          if (sufficient) begin
            state_d     = StDispense;
            enter_d     = 1'b1;
            erro_d      = 1'b0;
            err_cnt_d   = '0;
            drink_d     = drink_sel;
            chg_valid_d = 1'b1;
            chg_amt_d   = credit_q - price;
            credit_d    = '0;
          end else begin
            state_d   = StError;
            erro_d    = 1'b1;
            err_cnt_d = CntW'(ERR_CYCLES - 1);
          end
        end else if (coin_nz) begin
          if (coin_ovf) begin
            coin_rej_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            if (state_q == StIdle) begin
              state_d = StCredit;
            end
          end
        end
      end

      StDispense: begin
        state_d    = StWaitDone;
        coin_rej_d = coin_nz;
      end

      StWaitDone: begin
        coin_rej_d = coin_nz;
        if (drink_done) begin
          state_d = StIdle;
          drink_d = Drink0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      credit_q    <= '0;
      enter_q     <= 1'b0;
      erro_q      <= 1'b0;
      drink_q     <= Drink0;
      chg_valid_q <= 1'b0;
      chg_amt_q   <= '0;
      coin_rej_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      enter_q     <= enter_d;
      erro_q      <= erro_d;
      drink_q     <= drink_d;
      chg_valid_q <= chg_valid_d;
      chg_amt_q   <= chg_amt_d;
      coin_rej_q  <= coin_rej_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ENTER        = enter_q;
  assign ERRO         = erro_q;
  assign drink_out    = drink_q;
  assign credit       = credit_q;
  assign change_valid = chg_valid_q;
  assign change_amt   = chg_amt_q;
  assign coin_reject  = coin_rej_q;
  assign busy         = (state_q == StDispense) || (state_q == StWaitDone);

endmodule

// File: tb/tb_coffee_order_ctrl.sv
// Self-checking bench for coffee_order_ctrl: a behavioural order model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_coffee_order_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] coin;
  logic [1:0] drink_sel;
  logic       confirm;
  logic       cancel;
  logic       drink_done;
  logic       ENTER;
  logic       ERRO;
  logic [1:0] drink_out;
  logic [3:0] credit;
  logic       change_valid;
  logic [3:0] change_amt;
  logic       coin_reject;
  logic       busy;

  int checks = 0;
  int errors = 0;

  coffee_order_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .coin         (coin),
    .drink_sel    (drink_sel),
    .confirm      (confirm),
    .cancel       (cancel),
    .drink_done   (drink_done),
    .ENTER        (ENTER),
    .ERRO         (ERRO),
    .drink_out    (drink_out),
    .credit       (credit),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .coin_reject  (coin_reject),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: credit in plain integers, the order "phase" says whether a drink
  // is being dispensed (1), waited for (2), or the machine is taking money (0).
  int prices [4] = '{3, 4, 5, 6};
  int coinv  [4] = '{0, 1, 2, 5};
  int m_credit, m_drink, m_ca, m_phase, m_err_left;
  bit m_enter, m_erro, m_cv, m_rej;

  task automatic model_step();
    int v;
    v = coinv[coin];
    m_enter = 0;
    m_cv    = 0;
    m_rej   = 0;
    if (reset) begin
      m_credit = 0; m_erro = 0; m_drink = 0; m_ca = 0; m_phase = 0; m_err_left = 0;
    end else if (m_phase == 0) begin
      if (m_err_left > 0) m_err_left--;
      if (cancel) begin
        m_cv = 1; m_ca = m_credit; m_credit = 0; m_err_left = 0; m_rej = (v != 0);
      end else if (confirm) begin
        m_rej = (v != 0);
        if (m_credit >= prices[drink_sel]) begin
          m_enter = 1; m_drink = drink_sel; m_cv = 1; m_ca = m_credit - prices[drink_sel];
          m_credit = 0; m_phase = 1; m_err_left = 0;
        end else begin
          m_err_left = 4;
        end
      end else if (v != 0) begin
        if (m_credit + v > 15) m_rej = 1;
        else m_credit = m_credit + v;
      end
      m_erro = (m_err_left > 0);
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_rej = (v != 0);
    end else begin
      m_rej = (v != 0);
      if (drink_done) begin
        m_phase = 0;
        m_drink = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("enter", ENTER, m_enter);
    chk("erro", ERRO, m_erro);
    chk("drink_out", drink_out, m_drink);
    chk("credit", credit, m_credit);
    chk("change_valid", change_valid, m_cv);
    if (m_cv) chk("change_amt", change_amt, m_ca);
    chk("coin_reject", coin_reject, m_rej);
    chk("busy", busy, m_phase != 0);
    chk("enter_erro_excl", ENTER & ERRO, 0);
  endtask

  // Compare process: model advances on each edge, DUT checked 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
    end
  end

  task automatic drive(input logic [1:0] c, input logic [1:0] s, input logic cf,
                       input logic cn, input logic dn);
    @(negedge clk);
    coin = c; drink_sel = s; confirm = cf; cancel = cn; drink_done = dn;
  endtask

  task automatic idle();
    drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add(input logic [1:0] c);
    drive(c, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  int erro_len;

  initial begin
    reset = 1'b1; coin = 0; drink_sel = 0; confirm = 0; cancel = 0; drink_done = 0;
    repeat (2) @(negedge clk);
    chk("rst_credit", credit, 0);
    chk("rst_enter", ENTER, 0);
    chk("rst_erro", ERRO, 0);
    chk("rst_drink", drink_out, 0);
    chk("rst_cv", change_valid, 0);
    chk("rst_ca", change_amt, 0);
    chk("rst_rej", coin_reject, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // Exact payment for drink 00.
    add(2'b10);
    add(2'b01);
    drive(2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("t1_credit3", credit, 3);
    idle();
    chk("t1_enter", ENTER, 1);
    chk("t1_cv", change_valid, 1);
    chk("t1_ca", change_amt, 0);
    chk("t1_credit0", credit, 0);
    chk("t1_busy", busy, 1);
    idle();
    chk("t1_enter_1cyc", ENTER, 0);
    chk("t1_busy_wait", busy, 1);
    drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_drink", drink_out, 0);

    // Insufficient credit, ERRO length, then top up and succeed.
    add(2'b11);
    drive(2'd0, 2'd3, 1'b1, 1'b0, 1'b0);
    erro_len = 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (ERRO) erro_len++;
    end
    chk("t2_erro_len", erro_len, 4);
    chk("t2_credit_kept", credit, 5);
    add(2'b01);
    drive(2'd0, 2'd3, 1'b1, 1'b0, 1'b0);
    idle();
    chk("t2_enter", ENTER, 1);
    chk("t2_ca", change_amt, 0);
    chk("t2_drink", drink_out, 3);
    drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle();

    // Saturation at 15 and change of 10.
    add(2'b11);
    add(2'b11);
    add(2'b11);
    add(2'b11);
    idle();
    chk("t3_reject", coin_reject, 1);
    chk("t3_credit15", credit, 15);
    drive(2'd0, 2'd2, 1'b1, 1'b0, 1'b0);
    idle();
    chk("t3_enter", ENTER, 1);
    chk("t3_ca", change_amt, 10);
    drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle();

    // Cancel refunds; cancel beats confirm.
    add(2'b11);
    add(2'b10);
    drive(2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("t4_cv", change_valid, 1);
    chk("t4_ca", change_amt, 7);
    chk("t4_credit0", credit, 0);
    add(2'b01);
    drive(2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    idle();
    chk("t4_no_enter", ENTER, 0);
    chk("t4_cv2", change_valid, 1);
    chk("t4_ca2", change_amt, 1);
    chk("t4_busy", busy, 0);

    // Coins and confirm ignored while waiting; coin+confirm in CREDIT.
    add(2'b11);
    add(2'b01);
    drive(2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("t5_ca3", change_amt, 3);
    add(2'b01);
    idle();
    chk("t5_wait_reject", coin_reject, 1);
    chk("t5_wait_credit", credit, 0);
    drive(2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("t5_wait_no_enter", ENTER, 0);
    chk("t5_wait_busy", busy, 1);
    drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle();
    add(2'b10);
    drive(2'b01, 2'd0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("t5_erro", ERRO, 1);
    chk("t5_reject", coin_reject, 1);
    chk("t5_credit2", credit, 2);
    drive(2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("t5_refund", change_amt, 2);

    // Reset while in ERROR with credit 9.
    drive(2'd0, 2'd3, 1'b1, 1'b0, 1'b0);
    add(2'b11);
    add(2'b10);
    add(2'b10);
    @(negedge clk);
    chk("t6_credit9", credit, 9);
    chk("t6_erro", ERRO, 1);
    reset = 1'b1; coin = 0; confirm = 0; cancel = 0; drink_done = 0;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_credit0", credit, 0);
    chk("t6_erro0", ERRO, 0);
    chk("t6_no_cv", change_valid, 0);
    chk("t6_ca0", change_amt, 0);
    chk("t6_busy", busy, 0);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
